uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_tick.sv | 36 +++
 rtl/uart_rx.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receiver.
//   rx_state_e  - receiver FSM state encoding
//   OVS_RATE    - oversample ticks per bit (fixed at 16)
//   DATA_WIDTH  - payload bits per frame
//   MID_TICK    - tick index (0-based) of the start-bit mid-point
//   even_parity - parity bit that makes the total count of ones even
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } rx_state_e;

    localparam int unsigned OVS_RATE   = 16;
    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned MID_TICK   = 7;

    function automatic logic even_parity(input logic [DATA_WIDTH-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// uart_rx_tick: oversample tick generator.
//   clk_in  - clock
//   rst_n   - synchronous active-low reset
//   restart - clears the divider so the next tick lands OVS_DIV cycles later
//   tick    - one-cycle pulse every OVS_DIV clk_in cycles
module uart_rx_tick #(
    parameter int unsigned OVS_DIV = 10
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam logic [15:0] CntMax = 16'(OVS_DIV - 1);

    logic [15:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CntMax);

    always_comb begin
        cnt_d = cnt_q + 16'd1;
        if (restart || tick) begin
            cnt_d = 16'd0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampling UART receiver, 8N1 (8E1 when UART_RX_PARITY_EN is defined).
//   clk_in     - clock, all state on its rising edge
//   rst_n      - synchronous active-low reset
//   rx         - asynchronous serial line, idles high
//   data_out   - last good byte, held until the next good byte
//   data_valid - one-cycle pulse, data_out valid in that cycle
//   frame_err  - one-cycle pulse, stop bit sampled low
//   parity_err - one-cycle pulse on even-parity mismatch (UART_RX_PARITY_EN only)
module uart_rx #(
    parameter int unsigned OVS_DIV  = 10,
    parameter int unsigned OVS_RATE = 16
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       frame_err
);
    import uart_pkg::*;

    localparam logic [3:0] OvsLast = 4'(OVS_RATE - 1);
    localparam logic [3:0] OvsMid  = 4'(MID_TICK);
    localparam logic [2:0] IdxLast = 3'(DATA_WIDTH - 1);

    // Synchronizer and edge detection
    logic       rx_meta_q, rx_sync_q, rx_prev_q;
    logic [1:0] prime_q;
    logic       armed_q;
    logic       fall_edge;

    // FSM and datapath
    rx_state_e  state_q, state_d;
    logic [3:0] ovs_q, ovs_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shift_q, shift_d;
`ifdef UART_RX_PARITY_EN
    logic       par_q, par_d;
    logic       parity_err_q, parity_err_d;
`endif

    // Registered outputs
    logic [7:0] data_out_q, data_out_d;
    logic       data_valid_q, data_valid_d;
    logic       frame_err_q, frame_err_d;

    logic tick, restart, mid_hit, bit_hit;

    // armed_q stays low until the synchronizer holds real line samples and the line has been
    // seen high, so the preset-to-1 values cannot fake a start edge when reset releases while
    // the line is low mid-frame.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            prime_q   <= 2'd0;
            armed_q   <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            if (prime_q != 2'd2) begin
                prime_q <= prime_q + 2'd1;
            end
            if (prime_q == 2'd2 && rx_sync_q) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign fall_edge = armed_q & rx_prev_q & ~rx_sync_q;
    assign restart   = (state_q == StIdle) & fall_edge;
    assign mid_hit   = tick & (ovs_q == OvsMid);
    assign bit_hit   = tick & (ovs_q == OvsLast);

    uart_rx_tick #(
        .OVS_DIV (OVS_DIV)
    ) u_tick (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .restart (restart),
        .tick    (tick)
    );

    // State register and datapath registers
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ovs_q   <= 4'd0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ovs_q   <= ovs_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (fall_edge) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                // A high line at the start-bit mid-point is a glitch
                if (mid_hit) begin
                    state_d = rx_sync_q ? StIdle : StData;
                end
            end
            StData: begin
                if (bit_hit && idx_q == IdxLast) begin
`ifdef UART_RX_PARITY_EN
                    state_d = StParity;
`else
                    state_d = StStop;
`endif
                end
            end
            StParity: begin
                if (bit_hit) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (bit_hit) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Oversample counter, bit index and shift register
    always_comb begin
        ovs_d   = ovs_q;
        idx_d   = idx_q;
        shift_d = shift_q;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            StIdle: begin
                ovs_d = 4'd0;
                idx_d = 3'd0;
            end
            StStart: begin
                // Restart from the mid-point so later samples fall mid-bit
                if (tick) begin
                    ovs_d = mid_hit ? 4'd0 : ovs_q + 4'd1;
                end
            end
            StData: begin
                if (tick) begin
                    ovs_d = bit_hit ? 4'd0 : ovs_q + 4'd1;
                end
                if (bit_hit) begin
                    shift_d[idx_q] = rx_sync_q;
                    idx_d          = idx_q + 3'd1;
                end
            end
            StParity: begin
                if (tick) begin
                    ovs_d = bit_hit ? 4'd0 : ovs_q + 4'd1;
                end
`ifdef UART_RX_PARITY_EN
                if (bit_hit) begin
                    par_d = rx_sync_q;
                end
`endif
            end
            StStop: begin
                if (tick) begin
                    ovs_d = bit_hit ? 4'd0 : ovs_q + 4'd1;
                end
            end
            default: begin
                ovs_d = 4'd0;
                idx_d = 3'd0;
            end
        endcase
    end

    // Output next-state: framing error wins over parity error, either blocks data_valid
    always_comb begin
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err_d = 1'b0;
`endif
        if (state_q == StStop && bit_hit) begin
            if (!rx_sync_q) begin
                frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (par_q != even_parity(shift_q)) begin
                parity_err_d = 1'b1;
`endif
            end else begin
                data_valid_d = 1'b1;
                data_out_d   = shift_q;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            data_out_q   <= 8'h00;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule
